serial_adder_ctrl: RTL and testbench

Bit-serial N-bit adder controller. It sequences a single internal full-adder bit cell across WIDTH cycles, LSB first, using a carry flip-flop and operand shift registers. It trades area for latency: one full adder replaces a WIDTH-bit ripple chain. A start/busy/done handshake lets a host issue one addition at a time.

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder. A single full-adder cell is stepped across the
// operands LSB first, one bit per clock, using operand shift registers, a
// carry flop and a bit counter. The host starts one addition at a time with
// start and sees busy while bits are processed and a one-cycle done pulse
// when sum/cout take the new result.
//
// Timeline for a start accepted at edge k:
//   edges k+1 .. k+WIDTH-1 : intermediate bits, busy=1
//   edge  k+WIDTH          : last bit, sum/cout updated, enter DONE
//   edge  k+WIDTH+1        : back to IDLE, a new start may be taken
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must reach WIDTH-1. It is sized to hold WIDTH so that
    // WIDTH=1 still gets a one-bit counter.
    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Full-adder cell outputs and the result register after this bit.
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] res_next;

    // Single full-adder cell working on the current operand LSBs.
    always_comb begin
        // NOTE: every combinational output gets a value before any
        // conditional logic, so no path leaves one unassigned and no latch
        // is inferred.
        bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        bit_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        // New sum bit enters from the MSB side so that after WIDTH steps the
        // first (LSB) result bit has travelled down to bit 0. Written as a
        // shift plus MSB overwrite so that WIDTH=1 needs no special case.
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = bit_sum;
    end

    // Control FSM, datapath shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are cleared along with the control
            // state, so a reset mid-operation leaves nothing stale behind and
            // the reset value of sum/cout is defined.
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // below sees the pre-edge value of the others regardless of
            // statement order.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_carry;
                    res_sr <= res_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Last bit: publish the completed result.
                        sum   <= res_next;
                        cout  <= bit_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // One-cycle done pulse; start is ignored here.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl. One WIDTH=8 instance covers the
// handshake timing, carry propagation, held-start behaviour, asynchronous
// reset mid-operation and a random regression; one WIDTH=1 instance covers
// the full-adder truth table. Outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;

    // WIDTH=8 instance signals
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    // WIDTH=1 instance signals
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks;
    int failures;

    // Result the WIDTH=8 instance is expected to be holding.
    logic [8:0] held;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 addition through the handshake, checking latency, busy,
    // done, the result and that the previous result is held meanwhile.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           input string tag);
        logic [8:0] exp;
        int n;
        exp   = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        step();
        start = 1'b0;
        // Operands may change freely after capture.
        a     = ~ta;
        b     = ~tb_v;
        cin   = ~tc;
        n     = 0;
        while (done !== 1'b1 && n < 20) begin
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            check({tag, "_hold"}, {55'd0, cout, sum}, {55'd0, held});
            step();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd8);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_result"}, {55'd0, cout, sum}, {55'd0, exp});
        held = exp;
        step();
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    // One WIDTH=1 addition: done must appear two edges after start is driven.
    task automatic run_op1(input logic ta, input logic tb_v, input logic tc,
                           input logic exp_cout, input logic exp_sum, input string tag);
        a1     = ta;
        b1     = tb_v;
        cin1   = tc;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check({tag, "_busy"}, {62'd0, busy1, done1}, 64'b10);
        step();
        check({tag, "_done"}, {62'd0, busy1, done1}, 64'b01);
        check({tag, "_result"}, {62'd0, cout1, sum1[0]}, {62'd0, exp_cout, exp_sum});
        step();
        check({tag, "_idle"}, {62'd0, busy1, done1}, 64'b00);
    endtask

    initial begin
        logic [8:0] exp_v;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        checks   = 0;
        failures = 0;
        held     = 9'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        cin      = 1'b0;
        start1   = 1'b0;
        a1       = 1'b0;
        b1       = 1'b0;
        cin1     = 1'b0;

        // Reset state
        step();
        step();
        check("reset_w8", {53'd0, busy, done, cout, sum}, 64'd0);
        check("reset_w1", {60'd0, busy1, done1, cout1, sum1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {62'd0, busy, done}, 64'd0);

        // Directed WIDTH=8 additions
        run_op8(8'h0F, 8'h01, 1'b0, "add_0f_01");   // 0x010
        run_op8(8'hFF, 8'h01, 1'b0, "add_ff_01");   // 0x100
        run_op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_1"); // 0x1FF
        run_op8(8'h00, 8'h00, 1'b1, "add_00_00_1"); // 0x001
        run_op8(8'h80, 8'h80, 1'b0, "add_80_80");   // 0x100

        // Start held high with operands changing every cycle: accepts on
        // loop edges 0, 10, 20; done seen after edges 8, 18, 28.
        exp_v = 9'd0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a   = 8'(i * 37 + 11);
            b   = 8'(i * 91 + 200);
            cin = i[0];
            if (i % 10 == 0)
                exp_v = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            step();
            check("held_start_busy", {63'd0, busy}, {63'd0, (i % 10) <= 7});
            check("held_start_done", {63'd0, done}, {63'd0, (i % 10) == 8});
            if (i % 10 == 8) begin
                check("held_start_result", {55'd0, cout, sum}, {55'd0, exp_v});
                held = exp_v;
            end
        end
        start = 1'b0;
        step();
        check("held_start_idle", {62'd0, busy, done}, 64'd0);

        // Reset between edges during the 4th RUN cycle.
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", {53'd0, busy, done, cout, sum}, 64'd0);
        held = 9'd0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("no_done_after_reset", {62'd0, busy, done}, 64'd0);
        end
        run_op8(8'hAA, 8'h55, 1'b1, "after_reset"); // 0x100

        // WIDTH=1 full-adder truth table
        run_op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fa_000");
        run_op1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "fa_001");
        run_op1(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "fa_010");
        run_op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "fa_011");
        run_op1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "fa_100");
        run_op1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fa_101");
        run_op1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "fa_110");
        run_op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "fa_111");

        // Random WIDTH=8 regression
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            run_op8(ra, rb, rc, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
